// File: rtl/edp_pkg.sv
// Shared encodings for the EDP multiply/divide sequencer.
// Op codes, sequencer states and small op-decode helpers.
package edp_pkg;

  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_MULS = 2'b01,
    OP_DIVU = 2'b10,
    OP_DIVS = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/edp_addsub.sv
// Parametrised add/subtract with carry-in and carry-out.
// In subtract mode the carry-out is the inverted borrow.
module edp_addsub #(
  parameter int W = 37
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W-1:0] w_b;

  assign w_b             = i_sub ? ~i_b : i_b;
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {{W{1'b0}}, i_cin};

endmodule

// File: rtl/edp_muldiv_seq.sv
// Radix-2 multiply/divide step sequencer (AR/MQ style) with start/busy/done handshake.
// The result registers double as the working accumulators, so abort leaves partial contents.
module edp_muldiv_seq
  import edp_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             abort,
  input  logic [WIDTH-1:0] aHi,
  input  logic [WIDTH-1:0] aLo,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [WIDTH-1:0] resHi,
  output logic [WIDTH-1:0] resLo
);

  state_e             r_state, w_state_nxt;
  op_e                r_op, w_op_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_hi, w_hi_nxt;
  logic [WIDTH-1:0]   r_lo, w_lo_nxt;
  logic [WIDTH-1:0]   r_opnd, w_opnd_nxt;
  logic               r_neg_res, w_neg_res_nxt;
  logic               r_neg_rem, w_neg_rem_nxt;
  logic               r_ovf, w_ovf_nxt;

  logic               w_is_div, w_is_signed;
  logic               w_sign_lo, w_sign_dvd, w_sign_b;
  logic [WIDTH-1:0]   w_mcand_mag, w_b_mag;
  logic [2*WIDTH-1:0] w_dvd_mag;
  logic               w_div_ovf, w_quo_ovf;

  logic [WIDTH:0]     w_add_a, w_add_b, w_add_sum;
  logic               w_add_sub, w_add_cin, w_add_cout;
  logic [WIDTH-1:0]   w_lo_sum;
  logic               w_lo_cout;

  assign w_is_div    = op_is_div(r_op);
  assign w_is_signed = op_is_signed(r_op);

  // Operand signs only matter for signed ops; PREP reads the raw operands latched at start.
  assign w_sign_lo   = w_is_signed & r_lo[WIDTH-1];
  assign w_sign_dvd  = w_is_signed & r_hi[WIDTH-1];
  assign w_sign_b    = w_is_signed & r_opnd[WIDTH-1];
  assign w_mcand_mag = w_sign_lo  ? -r_lo : r_lo;
  assign w_b_mag     = w_sign_b   ? -r_opnd : r_opnd;
  assign w_dvd_mag   = w_sign_dvd ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_div_ovf   = w_is_div & (w_dvd_mag[2*WIDTH-1:WIDTH] >= w_b_mag);

  // Quotient magnitude out of signed range; -2**(WIDTH-1) is the one legal top-bit value.
  assign w_quo_ovf   = r_lo[WIDTH-1] & ~(r_neg_res & ~|r_lo[WIDTH-2:0]);

  edp_addsub #(.W(WIDTH+1)) u_add_hi (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_sub  (w_add_sub),
    .i_cin  (w_add_cin),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

  // Low-word negation; its carry-out (low word == 0) feeds the high-word negation.
  edp_addsub #(.W(WIDTH)) u_add_lo (
    .i_a    (~r_lo),
    .i_b    ({WIDTH{1'b0}}),
    .i_sub  (1'b0),
    .i_cin  (1'b1),
    .o_sum  (w_lo_sum),
    .o_cout (w_lo_cout)
  );

  assign busy  = (r_state != IDLE);
  assign done  = (r_state == DONE);
  assign ovf   = r_ovf;
  assign resHi = r_hi;
  assign resLo = r_lo;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_opnd_nxt    = r_opnd;
    w_neg_res_nxt = r_neg_res;
    w_neg_rem_nxt = r_neg_rem;
    w_ovf_nxt     = r_ovf;
    w_add_a       = '0;
    w_add_b       = '0;
    w_add_sub     = 1'b0;
    w_add_cin     = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = PREP;
          w_op_nxt    = op_e'(op);
          w_hi_nxt    = aHi;
          w_lo_nxt    = aLo;
          w_opnd_nxt  = b;
        end
      end

      PREP: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_ovf_nxt     = w_div_ovf;
          w_neg_res_nxt = (w_is_div ? w_sign_dvd : w_sign_lo) ^ w_sign_b;
          w_neg_rem_nxt = w_sign_dvd;
          if (w_div_ovf) begin
            // Raw aHi/aLo stay in the result registers; FIX passes them through.
            w_state_nxt = FIX;
          end else begin
            w_state_nxt = ITER;
            w_cnt_nxt   = CNT_W'(WIDTH-1);
            if (w_is_div) begin
              w_opnd_nxt         = w_b_mag;
              {w_hi_nxt, w_lo_nxt} = w_dvd_mag;
            end else begin
              w_opnd_nxt = w_mcand_mag;
              w_lo_nxt   = w_b_mag;
              w_hi_nxt   = '0;
            end
          end
        end
      end

      ITER: begin
        if (w_is_div) begin
          w_add_a   = {r_hi, r_lo[WIDTH-1]};
          w_add_b   = {1'b0, r_opnd};
          w_add_sub = 1'b1;
          w_add_cin = 1'b1;
        end else begin
          w_add_a   = {1'b0, r_hi};
          w_add_b   = {1'b0, r_opnd & {WIDTH{r_lo[0]}}};
        end
        if (abort) begin
          w_state_nxt = IDLE;
        end else begin
          if (w_is_div) begin
            w_hi_nxt = w_add_cout ? w_add_sum[WIDTH-1:0] : {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
            w_lo_nxt = {r_lo[WIDTH-2:0], w_add_cout};
          end else begin
            w_hi_nxt = w_add_sum[WIDTH:1];
            w_lo_nxt = {w_add_sum[0], r_lo[WIDTH-1:1]};
          end
          if (r_cnt == '0) begin
            w_state_nxt = FIX;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end

      FIX: begin
        w_add_a   = {1'b0, ~r_hi};
        w_add_cin = w_is_div ? 1'b1 : w_lo_cout;
        if (abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
          if (!r_ovf) begin
            if (r_op == OP_MULS && r_neg_res) begin
              w_hi_nxt = w_add_sum[WIDTH-1:0];
              w_lo_nxt = w_lo_sum;
            end else if (r_op == OP_DIVS) begin
              if (r_neg_res) w_lo_nxt = w_lo_sum;
              if (r_neg_rem) w_hi_nxt = w_add_sum[WIDTH-1:0];
              w_ovf_nxt = w_quo_ovf;
            end
          end
        end
      end

      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_op      <= OP_MULU;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opnd    <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_op      <= w_op_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_opnd    <= w_opnd_nxt;
      r_neg_res <= w_neg_res_nxt;
      r_neg_rem <= w_neg_rem_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_edp_muldiv_seq.sv
// Scoreboard bench for edp_muldiv_seq (WIDTH=36): expected results come from a
// wide-arithmetic reference model and are compared when done pulses.
module tb_edp_muldiv_seq;
  import edp_pkg::*;

  localparam int W = 36;
  localparam logic signed [2*W:0] ONE   = 1;
  localparam logic signed [2*W:0] Q_MAX = (ONE <<< (W-1)) - ONE;
  localparam logic signed [2*W:0] Q_MIN = -(ONE <<< (W-1));

  logic         clk = 1'b0;
  logic         resetN = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] aHi = '0, aLo = '0, b = '0;
  logic         busy, done, ovf;
  logic [W-1:0] resHi, resLo;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         ovf;
    int           lat;
  } exp_t;

  exp_t sb_q[$];

  edp_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk    (clk),
    .resetN (resetN),
    .start  (start),
    .op     (op),
    .abort  (abort),
    .aHi    (aHi),
    .aLo    (aLo),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .resHi  (resHi),
    .resLo  (resLo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] neg(input logic [W-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] ah, al, bb);
    exp_t                  e;
    logic [2*W-1:0]        up, uq, ur;
    logic signed [2*W-1:0] sp;
    logic signed [2*W:0]   sd, sdv, sq, sr, aq;
    e.hi = '0; e.lo = '0; e.ovf = 1'b0; e.lat = W + 2;
    case (o)
      2'b00: begin
        up = {{W{1'b0}}, al} * {{W{1'b0}}, bb};
        {e.hi, e.lo} = up;
      end
      2'b01: begin
        sp = $signed({{W{al[W-1]}}, al}) * $signed({{W{bb[W-1]}}, bb});
        {e.hi, e.lo} = sp;
      end
      2'b10: begin
        if (bb == '0) begin
          e.ovf = 1'b1; e.hi = ah; e.lo = al; e.lat = 2;
        end else begin
          uq = {ah, al} / {{W{1'b0}}, bb};
          ur = {ah, al} % {{W{1'b0}}, bb};
          if (uq[2*W-1:W] != '0) begin
            e.ovf = 1'b1; e.hi = ah; e.lo = al; e.lat = 2;
          end else begin
            e.lo = uq[W-1:0];
            e.hi = ur[W-1:0];
          end
        end
      end
      default: begin
        if (bb == '0) begin
          e.ovf = 1'b1; e.hi = ah; e.lo = al; e.lat = 2;
        end else begin
          sd  = $signed({ah[W-1], ah, al});
          sdv = $signed({{(W+1){bb[W-1]}}, bb});
          sq  = sd / sdv;
          sr  = sd % sdv;
          aq  = (sq < 0) ? -sq : sq;
          if (aq[2*W:W] != '0) begin
            e.ovf = 1'b1; e.hi = ah; e.lo = al; e.lat = 2;
          end else begin
            e.ovf = (sq > Q_MAX) || (sq < Q_MIN);
            e.lo  = sq[W-1:0];
            e.hi  = sr[W-1:0];
          end
        end
      end
    endcase
    return e;
  endfunction

  task automatic run_op(input string name, input logic [1:0] o,
                        input logic [W-1:0] ah, input logic [W-1:0] al, input logic [W-1:0] bb);
    exp_t e;
    int   edges;
    sb_q.push_back(model(o, ah, al, bb));
    @(negedge clk);
    start = 1'b1; op = o; aHi = ah; aLo = al; b = bb;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_busy"}, 72'(busy), 72'(1));
    edges = 0;
    while (!done && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    e = sb_q.pop_front();
    check({name, "_lat"}, 72'(edges), 72'(e.lat));
    check({name, "_hi"},  72'(resHi), 72'(e.hi));
    check({name, "_lo"},  72'(resLo), 72'(e.lo));
    check({name, "_ovf"}, 72'(ovf),   72'(e.ovf));
    @(posedge clk); #1;
    check({name, "_pulse"}, 72'({busy, done}), 72'(0));
  endtask

  initial begin
    int           n_done;
    logic [1:0]   ro;
    logic [W-1:0] rah, ral, rb;

    #2 resetN = 1'b0;
    #1;
    check("rst_busy", 72'(busy), 72'(0));
    check("rst_done", 72'(done), 72'(0));
    check("rst_ovf",  72'(ovf),  72'(0));
    check("rst_res",  72'({resHi, resLo}), 72'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) resetN = 1'b1;

    run_op("mulu_3x5",  OP_MULU, '0, 36'd3, 36'd5);
    run_op("muls_m1m1", OP_MULS, '0, neg(1), neg(1));
    run_op("muls_m2x3", OP_MULS, '0, neg(2), 36'd3);
    run_op("muls_min2", OP_MULS, '0, 36'h8_0000_0000, 36'h8_0000_0000);
    run_op("mulu_max",  OP_MULU, '0, '1, '1);
    run_op("divu_100",  OP_DIVU, '0, 36'd100, 36'd7);
    run_op("divs_m7",   OP_DIVS, '1, neg(7), 36'd2);
    run_op("divs_nb",   OP_DIVS, '0, 36'd100, neg(7));
    run_op("divs_qmin", OP_DIVS, '1, 36'h8_0000_0000, 36'd1);
    run_op("divs_qpos", OP_DIVS, '0, 36'h8_0000_0000, 36'd1);
    run_op("divu_ovf",  OP_DIVU, 36'd7, 36'd9, 36'd7);
    run_op("divs_z",    OP_DIVS, 36'd3, 36'd4, '0);
    run_op("divu_z",    OP_DIVU, 36'd5, 36'd11, '0);

    repeat (3) @(posedge clk);
    #1;
    check("ovf_hold", 72'(ovf),   72'(1));
    check("res_hold", 72'(resLo), 72'(11));

    for (int i = 0; i < 10; i++) begin
      ro  = 2'($urandom_range(0, 3));
      rb  = W'({$urandom(), $urandom()});
      ral = W'({$urandom(), $urandom()});
      rah = (i < 6) ? W'($urandom_range(0, 255)) : W'({$urandom(), $urandom()});
      run_op($sformatf("rand%0d", i), ro, rah, ral, rb);
    end

    // abort partway through ITER: no done, back to IDLE on the next edge
    @(negedge clk);
    start = 1'b1; op = OP_MULU; aHi = '0; aLo = 36'd12345; b = 36'd678;
    @(posedge clk); #1 start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_busy", 72'(busy), 72'(0));
    n_done = 0;
    repeat (45) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("abort_no_done", 72'(n_done), 72'(0));

    // start and abort together in IDLE: start is accepted
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = OP_MULU; aLo = 36'd2; b = 36'd2;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_wins", 72'(busy), 72'(1));
    @(negedge clk) abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_prep", 72'(busy), 72'(0));

    // start held high while busy: only one operation runs
    @(negedge clk);
    start = 1'b1; op = OP_MULU; aHi = '0; aLo = 36'd7; b = 36'd9;
    n_done = 0;
    for (int e = 0; e < 80; e++) begin
      @(posedge clk); #1;
      if (done) n_done++;
      if (e == W + 2) start = 1'b0;
    end
    check("held_one_done", 72'(n_done), 72'(1));
    check("held_result",   72'(resLo),  72'(63));
    check("held_idle",     72'(busy),   72'(0));

    // asynchronous reset in the middle of ITER
    @(negedge clk);
    start = 1'b1; op = OP_MULU; aLo = '1; b = '1;
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk) resetN = 1'b0;
    #1;
    check("midrst_busy", 72'(busy), 72'(0));
    check("midrst_ovf",  72'(ovf),  72'(0));
    check("midrst_res",  72'({resHi, resLo}), 72'(0));
    @(negedge clk) resetN = 1'b1;

    run_op("post_rst", OP_MULU, '0, 36'd6, 36'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
